// File: rtl/dut_cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dut_cmp_pkg
// Description : Shared state encoding, default sizing and first-error record
//               for the golden-vs-netlist compare monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package dut_cmp_pkg;

    localparam int C_NUM_VECTORS = 504;
    localparam int C_CNT_W       = 16;
    localparam int C_WIDTH       = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } cmp_state_t;

    // Reference layout of the captured first failure at default sizing
    typedef struct packed {
        logic [C_CNT_W-1:0] idx;
        logic [C_WIDTH-1:0] golden;
        logic [C_WIDTH-1:0] netlist;
    } first_err_t;

endpackage
`default_nettype wire

// File: rtl/dut_compare_monitor_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter with synchronous clear that holds at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/dut_compare_monitor.sv
`default_nettype none
// ============================================================================
// Module      : dut_compare_monitor
// Description : Bit-exact compare of golden vs netlist buses over a fixed
//               vector budget; counts, first-error capture, done/pass.
//               Optional CMP_DISPLAY_EN compiles in simulation reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module dut_compare_monitor
    import dut_cmp_pkg::*;
#(
    parameter int WIDTH       = C_WIDTH,
    parameter int CNT_W       = C_CNT_W,
    parameter int NUM_VECTORS = C_NUM_VECTORS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] golden,
    input  logic [WIDTH-1:0] netlist,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] compare_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             first_err_valid,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [WIDTH-1:0] first_err_golden,
    output logic [WIDTH-1:0] first_err_netlist
);

    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(NUM_VECTORS - 1);

    // Same field layout as first_err_t, sized by this instance's parameters
    typedef struct packed {
        logic [CNT_W-1:0] idx;
        logic [WIDTH-1:0] golden;
        logic [WIDTH-1:0] netlist;
    } err_rec_t;

    cmp_state_t       r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic             r_fev;
    err_rec_t         r_first;

    logic             w_start_run;
    logic             w_accept;
    logic             w_mis;
    logic             w_last;
    logic [CNT_W-1:0] w_cmp_cnt;
    logic [CNT_W-1:0] w_mis_cnt;

    assign w_start_run = start && (r_state != ST_RUN);
    assign w_accept    = sample_valid && (r_state == ST_RUN);
    assign w_mis       = (golden != netlist);
    assign w_last      = w_accept && (w_cmp_cnt == c_last_idx);

    sat_counter #(.CNT_W(CNT_W)) u_cmp_cnt (
        .clk (clk),
        .rst (rst),
        .clr (w_start_run),
        .inc (w_accept),
        .cnt (w_cmp_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_mis_cnt (
        .clk (clk),
        .rst (rst),
        .clr (w_start_run),
        .inc (w_accept && w_mis),
        .cnt (w_mis_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_fev   <= 1'b0;
            r_first <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                        r_fev   <= 1'b0;
                        r_first <= '0;
                    end
                end
                ST_RUN: begin
                    if (sample_valid) begin
                        if (w_mis && !r_fev) begin
                            r_fev           <= 1'b1;
                            r_first.idx     <= w_cmp_cnt;
                            r_first.golden  <= golden;
                            r_first.netlist <= netlist;
                        end
                        // Pass must reflect the final sample's own result
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= !w_mis && (w_mis_cnt == '0);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy              = r_busy;
    assign done              = r_done;
    assign pass              = r_pass;
    assign compare_cnt       = w_cmp_cnt;
    assign mismatch_cnt      = w_mis_cnt;
    assign first_err_valid   = r_fev;
    assign first_err_idx     = r_first.idx;
    assign first_err_golden  = r_first.golden;
    assign first_err_netlist = r_first.netlist;

`ifdef CMP_DISPLAY_EN
    always @(posedge clk) begin
        if (!rst && w_accept) begin
            $display("%0t golden=%h netlist=%h %s", $time, golden, netlist,
                     w_mis ? "Mismatch" : "Matched");
            if ($isunknown(netlist))
                $display("%0t netlist carries X/Z: Mismatch", $time);
            if (w_last) begin
                if (!w_mis && (w_mis_cnt == '0))
                    $display("All Comparison Matched / Simulation Passed");
                else
                    $display("%0d comparison(s) mismatched / Simulation Failed",
                             (w_mis && (w_mis_cnt != '1)) ? int'(w_mis_cnt) + 1 : int'(w_mis_cnt));
            end
        end
    end
`endif

endmodule
`default_nettype wire
